// File: rtl/cva6_ras_ckpt_pkg.sv
// -----------------------------------------------------------------------------
// cva6_ras_ckpt_pkg
// Shared types and constants for the checkpointed return-address stack.
//   - cva6_cfg_t / CVA6Cfg : minimal slice of the cva6 configuration. The
//     default stack depth is taken from its RASDepth field.
//   - ras_entry_t          : one return-address entry, sized for the widest
//     supported VLEN (64 bits).
//   - ras_ckpt_t           : a speculative snapshot {tos, count, top}. Its field
//     widths cover the largest legal stack (DEPTH = 16).
// -----------------------------------------------------------------------------
package cva6_ras_ckpt_pkg;

  typedef struct packed {
    int unsigned RASDepth;
    int unsigned VLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t CVA6Cfg = '{RASDepth: 32'd2, VLEN: 32'd64};

  localparam int unsigned RasDefaultDepth = CVA6Cfg.RASDepth;
  localparam int unsigned RasMaxVlen      = 64;
  // A 16-entry stack needs a 4-bit index and a 5-bit count (0..16).
  localparam int unsigned RasTosW         = 4;
  localparam int unsigned RasCntW         = 5;

  typedef logic [RasMaxVlen-1:0] ras_entry_t;

  typedef struct packed {
    logic [RasTosW-1:0] tos;
    logic [RasCntW-1:0] count;
    ras_entry_t         top;
  } ras_ckpt_t;

endpackage

// File: rtl/cva6_ras_ckpt_lzc.sv
// -----------------------------------------------------------------------------
// lzc
// Leading/trailing zero counter in the common-cells style.
//   in_i    : input vector
//   cnt_o   : MODE 0 -> index of the lowest set bit (trailing zeros)
//             MODE 1 -> number of leading zeros above the highest set bit
//   empty_o : no bit of in_i is set (cnt_o is 0 in that case)
// -----------------------------------------------------------------------------
module lzc #(
  parameter int unsigned WIDTH = 4,
  parameter bit          MODE  = 1'b0
) (
  input  logic [WIDTH-1:0]         in_i,
  output logic [$clog2(WIDTH)-1:0] cnt_o,
  output logic                     empty_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  // Scanning away from the end of interest lets the last hit win, which
  // gives priority to the bit nearest that end without a break statement.
  always_comb begin
    cnt_o = '0;
    if (MODE == 1'b0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CntW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) cnt_o = CntW'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~(|in_i);

endmodule

// File: rtl/cva6_ras_ckpt.sv
// -----------------------------------------------------------------------------
// cva6_ras_ckpt
// Circular return-address stack with speculative checkpoints for mispredict
// recovery.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   flush_i                  : empty the stack and free every checkpoint
//   push_i, data_i, pop_i    : call push / return pop
//   data_o, valid_o          : predicted return address at top of stack
//   ckpt_take_i              : snapshot the stack into the lowest free slot
//   ckpt_ready_o, ckpt_id_o  : a slot is free / index of that slot
//   restore_i, restore_id_i  : roll the stack back to a busy checkpoint
//   release_i, release_id_i  : branch resolved, free the checkpoint
//   overflow_o               : one-cycle pulse after a push dropped the oldest
//                              entry
// Supports VLEN up to 64 and DEPTH up to 16 (the checkpoint field widths).
// -----------------------------------------------------------------------------
module cva6_ras_ckpt
  import cva6_ras_ckpt_pkg::*;
#(
  parameter int unsigned DEPTH   = RasDefaultDepth,
  parameter int unsigned VLEN    = 64,
  parameter int unsigned NR_CKPT = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [VLEN-1:0]            data_i,
  input  logic                       pop_i,
  output logic [VLEN-1:0]            data_o,
  output logic                       valid_o,
  input  logic                       ckpt_take_i,
  output logic                       ckpt_ready_o,
  output logic [$clog2(NR_CKPT)-1:0] ckpt_id_o,
  input  logic                       restore_i,
  input  logic [$clog2(NR_CKPT)-1:0] restore_id_i,
  input  logic                       release_i,
  input  logic [$clog2(NR_CKPT)-1:0] release_id_i,
  output logic                       overflow_o
);

  localparam int unsigned IW   = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned CW   = $clog2(NR_CKPT);

  logic [VLEN-1:0]    r_entry [DEPTH];
  logic [IW-1:0]      r_tos;
  logic [CntW-1:0]    r_count;
  logic [NR_CKPT-1:0] r_free;
  ras_ckpt_t          r_ckpt [NR_CKPT];
  logic               r_overflow;

  logic [IW-1:0]      w_tos_inc;
  logic [IW-1:0]      w_tos_dec;
  logic [CW-1:0]      w_id;
  logic               w_none_free;
  logic               w_take;
  logic               w_restore;
  logic               w_release;
  ras_ckpt_t          w_snap;
  ras_ckpt_t          w_saved;
  logic [NR_CKPT-1:0] w_free_next;

  // Lowest free checkpoint slot.
  lzc #(
    .WIDTH (NR_CKPT),
    .MODE  (1'b0)
  ) i_free_lzc (
    .in_i    (r_free),
    .cnt_o   (w_id),
    .empty_o (w_none_free)
  );

  assign ckpt_ready_o = ~w_none_free;
  assign ckpt_id_o    = w_id;
  assign valid_o      = (r_count != '0);
  // Entries are stale after a flush, so the output is gated by occupancy.
  assign data_o       = valid_o ? r_entry[r_tos] : '0;
  assign overflow_o   = r_overflow;

  always_comb begin
    // DEPTH need not be a power of two, so wrap the index explicitly.
    w_tos_inc = (r_tos == IW'(DEPTH - 1)) ? '0 : r_tos + IW'(1);
    w_tos_dec = (r_tos == '0) ? IW'(DEPTH - 1) : r_tos - IW'(1);

    w_take    = ckpt_take_i & ckpt_ready_o & ~restore_i & ~flush_i;
    // Ids beyond NR_CKPT are possible when NR_CKPT is not a power of two.
    w_restore = restore_i && (int'(restore_id_i) < NR_CKPT) && !r_free[restore_id_i];
    w_release = release_i && (int'(release_id_i) < NR_CKPT);

    w_snap    = '{tos:   RasTosW'(r_tos),
                  count: RasCntW'(r_count),
                  top:   RasMaxVlen'(r_entry[r_tos])};
    w_saved   = r_ckpt[restore_id_i];

    // Release before take: a slot freed this cycle can't be the one taken,
    // since take only ever picks a slot that was already free.
    w_free_next = r_free;
    if (w_release) w_free_next[release_id_i] = 1'b1;
    if (w_restore) w_free_next[restore_id_i] = 1'b1;
    if (w_take)    w_free_next[w_id]         = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tos      <= '0;
      r_count    <= '0;
      r_free     <= '1;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++)   r_entry[i] <= '0;
      for (int i = 0; i < NR_CKPT; i++) r_ckpt[i]  <= '0;
    end else if (flush_i) begin
      r_tos      <= '0;
      r_count    <= '0;
      r_free     <= '1;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      r_free     <= w_free_next;
      if (w_take) r_ckpt[w_id] <= w_snap;

      // A restore replaces any push/pop issued in the same cycle.
      if (w_restore) begin
        r_tos                    <= IW'(w_saved.tos);
        r_count                  <= CntW'(w_saved.count);
        r_entry[IW'(w_saved.tos)] <= VLEN'(w_saved.top);
      end else if (push_i && pop_i) begin
        r_entry[r_tos] <= data_i;
        if (r_count == '0) r_count <= CntW'(1);
      end else if (push_i) begin
        r_tos            <= w_tos_inc;
        r_entry[w_tos_inc] <= data_i;
        if (r_count == CntW'(DEPTH)) r_overflow <= 1'b1;
        else                         r_count    <= r_count + CntW'(1);
      end else if (pop_i && (r_count != '0)) begin
        r_tos   <= w_tos_dec;
        r_count <= r_count - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cva6_ras_ckpt.sv
// -----------------------------------------------------------------------------
// tb_cva6_ras_ckpt
// Directed bench for cva6_ras_ckpt at DEPTH=4, VLEN=64, NR_CKPT=4. Each step
// drives one cycle of inputs, then outputs are compared against hand-computed
// values one time unit after the clock edge.
// -----------------------------------------------------------------------------
module tb_cva6_ras_ckpt;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned VLEN    = 64;
  localparam int unsigned NR_CKPT = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            push = 1'b0;
  logic [VLEN-1:0] dataIn = '0;
  logic            pop = 1'b0;
  logic [VLEN-1:0] dataOut;
  logic            validOut;
  logic            take = 1'b0;
  logic            ready;
  logic [1:0]      ckptId;
  logic            restore = 1'b0;
  logic [1:0]      restoreId = '0;
  logic            release_ = 1'b0;
  logic [1:0]      releaseId = '0;
  logic            overflow;

  int totalChecks = 0;
  int badChecks   = 0;

  always #5 clk = ~clk;

  cva6_ras_ckpt #(
    .DEPTH   (DEPTH),
    .VLEN    (VLEN),
    .NR_CKPT (NR_CKPT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .push_i       (push),
    .data_i       (dataIn),
    .pop_i        (pop),
    .data_o       (dataOut),
    .valid_o      (validOut),
    .ckpt_take_i  (take),
    .ckpt_ready_o (ready),
    .ckpt_id_o    (ckptId),
    .restore_i    (restore),
    .restore_id_i (restoreId),
    .release_i    (release_),
    .release_id_i (releaseId),
    .overflow_o   (overflow)
  );

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives one clock cycle of inputs, then returns the inputs to idle.
  task automatic applyStimulus(input logic iPush, input logic [63:0] iData, input logic iPop,
                               input logic iTake, input logic iRestore, input logic [1:0] iRid,
                               input logic iRel, input logic [1:0] iRelId, input logic iFlush);
    push = iPush; dataIn = iData; pop = iPop; take = iTake;
    restore = iRestore; restoreId = iRid; release_ = iRel; releaseId = iRelId; flush = iFlush;
    @(posedge clk);
    #1;
    push = 1'b0; dataIn = '0; pop = 1'b0; take = 1'b0;
    restore = 1'b0; restoreId = '0; release_ = 1'b0; releaseId = '0; flush = 1'b0;
  endtask

  task automatic doPush(input logic [63:0] d);
    applyStimulus(1, d, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doPop();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doTake();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic doFlush();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    // Reset state, observed while reset is still asserted.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_data",     dataOut,  64'h0);
    checkOutput("rst_valid",    validOut, 64'h0);
    checkOutput("rst_overflow", overflow, 64'h0);
    checkOutput("rst_ready",    ready,    64'h1);
    checkOutput("rst_id",       ckptId,   64'h0);
    rst = 1'b0;

    // Basic push/pop.
    doPush(64'h100);
    doPush(64'h200);
    doPush(64'h300);
    checkOutput("push3_data", dataOut, 64'h300);
    doPop();
    checkOutput("pop_data",  dataOut,  64'h200);
    checkOutput("pop_valid", validOut, 64'h1);
    doFlush();
    checkOutput("flush1_valid", validOut, 64'h0);

    // Overflow on the fifth push, then drain.
    for (int i = 1; i <= 4; i++) doPush(64'(i));
    checkOutput("ovf_before", overflow, 64'h0);
    doPush(64'h5);
    checkOutput("ovf_pulse", overflow, 64'h1);
    checkOutput("ovf_top",   dataOut,  64'h5);
    doPop();
    checkOutput("ovf_pulse_end", overflow, 64'h0);
    checkOutput("drain_1", dataOut, 64'h4);
    doPop();
    checkOutput("drain_2", dataOut, 64'h3);
    doPop();
    checkOutput("drain_3", dataOut, 64'h2);
    doPop();
    checkOutput("drain_empty_valid", validOut, 64'h0);
    doPop();
    checkOutput("drain_extra_valid", validOut, 64'h0);
    checkOutput("drain_extra_data",  dataOut,  64'h0);
    doFlush();

    // Checkpoint and restore.
    doPush(64'hA);
    checkOutput("ck_id_before", ckptId, 64'h0);
    doTake();
    checkOutput("ck_id_after", ckptId, 64'h1);
    doPop();
    doPop();
    doPush(64'hB);
    checkOutput("ck_spec_top", dataOut, 64'hB);
    applyStimulus(0, 0, 0, 0, 1, 2'd0, 0, 0, 0);
    checkOutput("restore_data",  dataOut,  64'hA);
    checkOutput("restore_valid", validOut, 64'h1);
    checkOutput("restore_ready", ready,    64'h1);
    checkOutput("restore_id",    ckptId,   64'h0);
    doPop();
    checkOutput("restore_count1", validOut, 64'h0);
    doFlush();

    // Exhausting the checkpoint slots.
    doTake();
    doTake();
    doTake();
    checkOutput("ck3_id", ckptId, 64'h3);
    doTake();
    checkOutput("ck4_ready", ready, 64'h0);
    doTake();
    checkOutput("ck5_ready", ready, 64'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2'd2, 0);
    checkOutput("rel2_id",    ckptId, 64'h2);
    checkOutput("rel2_ready", ready,  64'h1);
    // Release 1 and take (slot 2) in the same cycle: only slot 1 ends up free.
    applyStimulus(0, 0, 0, 1, 0, 0, 1, 2'd1, 0);
    checkOutput("reltake_id",    ckptId, 64'h1);
    checkOutput("reltake_ready", ready,  64'h1);
    doFlush();

    // Replace, replace on empty, and restore overriding a push.
    doPush(64'hA);
    applyStimulus(1, 64'hC, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("replace_data", dataOut, 64'hC);
    doPop();
    checkOutput("replace_count", validOut, 64'h0);
    applyStimulus(1, 64'hD, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("replace_empty_data",  dataOut,  64'hD);
    checkOutput("replace_empty_valid", validOut, 64'h1);
    doTake();
    doPush(64'hE);
    checkOutput("spec_push", dataOut, 64'hE);
    applyStimulus(1, 64'hF, 0, 0, 1, 2'd0, 0, 0, 0);
    checkOutput("restore_push_data", dataOut, 64'hD);
    doPop();
    checkOutput("restore_push_count", validOut, 64'h0);

    // Flush with two checkpoints busy.
    doPush(64'h77);
    doTake();
    doTake();
    checkOutput("pre_flush_id", ckptId, 64'h2);
    doFlush();
    checkOutput("flush_valid", validOut, 64'h0);
    checkOutput("flush_id",    ckptId,   64'h0);
    checkOutput("flush_ready", ready,    64'h1);
    doTake();
    doTake();
    doTake();
    checkOutput("flush_all_free", ckptId, 64'h3);
    doFlush();

    // Reset in the middle of a sequence with a full stack and a live checkpoint.
    for (int i = 0; i < 4; i++) doPush(64'h50 + 64'(i));
    doTake();
    rst = 1'b1;
    applyStimulus(1, 64'h99, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midrst_data",     dataOut,  64'h0);
    checkOutput("midrst_valid",    validOut, 64'h0);
    checkOutput("midrst_overflow", overflow, 64'h0);
    checkOutput("midrst_ready",    ready,    64'h1);
    checkOutput("midrst_id",       ckptId,   64'h0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 2'd0, 0, 0, 0);
    checkOutput("midrst_restore_valid", validOut, 64'h0);
    checkOutput("midrst_restore_id",    ckptId,   64'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
